// File: rtl/x_uart_pkg.sv
// Shared types and constants for the UART receive path.
// Holds the receiver state encoding and the frame data width.
package x_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_rx_state_t;

    localparam int UART_DATA_BITS = 8;

endpackage

// File: rtl/x_sync.sv
// Generic two-flop synchronizer for a single asynchronous input.
// Latency: two clocks from input change to output change.
// Backpressure: none; the output simply follows the input.
module x_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            dout <= RST_VAL;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/x_uart_rx.sv
// 8N1 LSB-first serial receiver: one-cycle o_valid per good byte, o_frame_err per bad stop.
// Latency: o_valid one clock after the mid-stop-bit sample (2 + HALF + 9*CLKS_PER_BIT + 1 from start edge).
// Backpressure: none; the consumer must accept every o_valid pulse.
module x_uart_rx
    import x_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_rx,
    output logic                      o_valid,
    output logic [UART_DATA_BITS-1:0] o_data,
    output logic                      o_frame_err
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = $clog2(UART_DATA_BITS);
    localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(UART_DATA_BITS - 1);

    if (CLKS_PER_BIT < 4) begin : g_param_chk
        $error("x_uart_rx: CLKS_PER_BIT must be at least 4");
    end

    uart_rx_state_t            state;
    uart_rx_state_t            state_nxt;
    logic                      rx_s;
    logic [CW-1:0]             cnt;
    logic [IW-1:0]             idx;
    logic [UART_DATA_BITS-1:0] shreg;
    logic                      half_hit;
    logic                      bit_hit;
    logic                      good_stop;
    logic                      bad_stop;

    x_sync #(.RST_VAL(1'b1)) u_rx_sync (
        .clk   (i_clk),
        .rst_n (i_rst),
        .din   (i_rx),
        .dout  (rx_s)
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (!rx_s) state_nxt = START;
            START:   if (half_hit) state_nxt = rx_s ? IDLE : DATA;
            DATA:    if (bit_hit && idx == IDX_LAST) state_nxt = STOP;
            STOP:    if (bit_hit) state_nxt = rx_s ? IDLE : BREAK;
            BREAK:   if (rx_s) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        half_hit  = (state == START) && (cnt == HALF_M1);
        bit_hit   = (cnt == BIT_LAST);
        good_stop = (state == STOP) && bit_hit && rx_s;
        bad_stop  = (state == STOP) && bit_hit && !rx_s;
    end

    // Timer restarts on every state change so DATA/STOP sample one full bit after the previous sample.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            cnt         <= '0;
            idx         <= '0;
            shreg       <= '0;
            o_valid     <= 1'b0;
            o_data      <= '0;
            o_frame_err <= 1'b0;
        end else begin
            o_valid     <= good_stop;
            o_frame_err <= bad_stop;
            if (good_stop) o_data <= shreg;

            if (state_nxt != state || bit_hit || state == IDLE || state == BREAK)
                cnt <= '0;
            else
                cnt <= cnt + CW'(1);

            if (state == START) begin
                idx <= '0;
            end else if (state == DATA && bit_hit) begin
                shreg[idx] <= rx_s;
                idx        <= idx + IW'(1);
            end
        end
    end

endmodule
